regfile_wb_arbiter: RTL and testbench

Write-back arbiter sitting directly upstream of the CPU's 32x32 register-file RAM, which has a single write port (wren, wraddress, data) committed on the rising clock edge. It merges three result sources onto that port:
- the ALU result stream, which is never stalled;
- the load-unit result stream, buffered in a small FIFO;
- the multiply/divide result, held in a single-entry register.

It also exports a pending-write mask so the decode stage can detect hazards.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges ALU, buffered load and mul/div results onto the single
// register-file write port. Optional same-cycle read forwarding under `WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int LD_DEPTH = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              alu_valid,
    input  logic [4:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [4:0]        md_dest,
    input  logic [DATA_W-1:0] md_data,
    output logic              wren,
    output logic [4:0]        wraddress,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       pending
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rf_q,
    output logic [DATA_W-1:0] rd_data
`endif
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);

    logic [4:0]        r_fd [LD_DEPTH];
    logic [DATA_W-1:0] r_fq [LD_DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_md_full;
    logic [4:0]        r_md_dest;
    logic [DATA_W-1:0] r_md_data;
    logic              r_wren;
    logic [4:0]        r_wraddress;
    logic [DATA_W-1:0] r_data;

    logic              w_fifo_ne, w_push, w_pop, w_md_drain, w_md_load, w_sel;
    logic [4:0]        w_sel_dest;
    logic [DATA_W-1:0] w_sel_data;
    logic [31:0]       w_pend;

    assign ld_ready   = resetn && (r_count != FULL_CNT);
    assign md_ready   = resetn && !r_md_full;
    assign w_fifo_ne  = (r_count != '0);
    assign w_push     = ld_valid && ld_ready;
    assign w_md_load  = md_valid && md_ready;
    assign w_pop      = !alu_valid && w_fifo_ne;
    assign w_md_drain = !alu_valid && !w_fifo_ne && r_md_full;
    assign w_sel      = alu_valid || w_fifo_ne || r_md_full;

    always_comb begin
        w_sel_dest = r_md_dest;
        w_sel_data = r_md_data;
        if (alu_valid) begin
            w_sel_dest = alu_dest;
            w_sel_data = alu_data;
        end else if (w_fifo_ne) begin
            w_sel_dest = r_fd[r_rptr];
            w_sel_data = r_fq[r_rptr];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wren      <= 1'b0;
            r_wraddress <= '0;
            r_data      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_md_full   <= 1'b0;
        end else begin
            // r0 entries are consumed like any other but never reach the port
            r_wren <= w_sel && (w_sel_dest != 5'd0);
            if (w_sel && (w_sel_dest != 5'd0)) begin
                r_wraddress <= w_sel_dest;
                r_data      <= w_sel_data;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_md_drain)     r_md_full <= 1'b0;
            else if (w_md_load) r_md_full <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fd[r_wptr] <= ld_dest;
            r_fq[r_wptr] <= ld_data;
        end
        if (w_md_load) begin
            r_md_dest <= md_dest;
            r_md_data <= md_data;
        end
    end

    // Entry i is live when its distance from the read pointer is below the count
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - r_rptr;
            if ({1'b0, off} < r_count) w_pend[r_fd[i]] = 1'b1;
        end
        if (r_md_full) w_pend[r_md_dest]   = 1'b1;
        if (r_wren)    w_pend[r_wraddress] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign pending   = w_pend;
    assign wren      = r_wren;
    assign wraddress = r_wraddress;
    assign data      = r_data;

`ifdef WB_FWD_EN
    assign rd_data = (r_wren && (r_wraddress == rd_addr) && (rd_addr != 5'd0)) ? r_data : rf_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, FIFO-full sequence and
// randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, md_valid = 1'b0;
    logic [4:0]  alu_dest = '0, ld_dest = '0, md_dest = '0;
    logic [31:0] alu_data = '0, ld_data = '0, md_data = '0;
    logic        ld_ready, md_ready, wren;
    logic [4:0]  wraddress;
    logic [31:0] data, pending;
`ifdef WB_FWD_EN
    logic [4:0]  rd_addr = '0;
    logic [31:0] rf_q = '0;
    logic [31:0] rd_data;
`endif

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.LD_DEPTH(D), .DATA_W(32)) dut (
        .clock(clock), .resetn(resetn),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_dest(md_dest), .md_data(md_data),
        .wren(wren), .wraddress(wraddress), .data(data), .pending(pending)
`ifdef WB_FWD_EN
        , .rd_addr(rd_addr), .rf_q(rf_q), .rd_data(rd_data)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: results waiting for the port, in arbitration terms
    typedef struct { logic [4:0] d; logic [31:0] v; } ent_t;
    ent_t        mq[$];
    bit          m_mdf = 0;
    ent_t        m_md;
    bit          m_wren = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          wlog[$];

    task automatic model_step();
        ent_t w;
        bit sel, push, mdacc;
        if (!resetn) begin
            mq.delete(); m_mdf = 0; m_wren = 0; m_addr = '0; m_data = '0;
            return;
        end
        push  = ld_valid && (mq.size() < D);
        mdacc = md_valid && !m_mdf;
        sel = 1;
        if (alu_valid)          w = '{alu_dest, alu_data};
        else if (mq.size() > 0) w = mq.pop_front();
        else if (m_mdf) begin   w = m_md; m_mdf = 0; end
        else                    sel = 0;
        if (push) mq.push_back('{ld_dest, ld_data});
        if (mdacc) begin m_mdf = 1; m_md = '{md_dest, md_data}; end
        m_wren = sel && (w.d != 0);
        if (m_wren) begin m_addr = w.d; m_data = w.v; end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].d] = 1'b1;
        if (m_mdf)  p[m_md.d] = 1'b1;
        if (m_wren) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        if (m_wren) wlog.push_back(int'(m_addr));
        chk("wren", wren, m_wren);
        chk("ld_ready", ld_ready, resetn && (mq.size() < D));
        chk("md_ready", md_ready, resetn && !m_mdf);
        chk("pending", pending, m_pend());
        if (m_wren) begin
            chk("wraddress", wraddress, m_addr);
            chk("data", data, m_data);
        end
    endtask

    typedef struct {
        bit rst, av; logic [4:0] ad; logic [31:0] adat;
        bit lv; logic [4:0] ld; logic [31:0] ldat;
        bit mv; logic [4:0] md; logic [31:0] mdat;
        bit e_wren; logic [4:0] e_addr; logic [31:0] e_data; logic [31:0] e_pend;
        bit e_ldr, e_mdr;
    } vec_t;

    function automatic vec_t mk(bit rst, bit av, logic [4:0] ad, logic [31:0] adat,
                                bit lv, logic [4:0] ld, logic [31:0] ldat,
                                bit mv, logic [4:0] md, logic [31:0] mdat,
                                bit ew, logic [4:0] ea, logic [31:0] ed, logic [31:0] ep,
                                bit elr, bit emr);
        vec_t v;
        v.rst = rst; v.av = av; v.ad = ad; v.adat = adat;
        v.lv = lv; v.ld = ld; v.ldat = ldat; v.mv = mv; v.md = md; v.mdat = mdat;
        v.e_wren = ew; v.e_addr = ea; v.e_data = ed; v.e_pend = ep; v.e_ldr = elr; v.e_mdr = emr;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        int li, acc, nld;
        // expected outputs are those seen just after the edge that consumes the row
        tbl[0]  = mk(1, 1, 3, 32'h1, 1, 4, 32'h2, 1, 5, 32'h3,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 3, 32'h1, 1, 4, 32'h2, 1, 5, 32'h3,   0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 3, 32'h1, 1, 4, 32'h2, 1, 5, 32'h3,   0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 32'h0, 1, 1);
        tbl[4]  = mk(0, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0,     1, 5, 32'h11, 32'h60, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               1, 6, 32'h22, 32'h40, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 6, 32'h22, 32'h0, 1, 1);
        tbl[7]  = mk(0, 1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 0,       1, 1, 32'h1, 32'h6, 1, 1);
        tbl[8]  = mk(0, 1, 3, 32'h3, 1, 4, 32'h4, 1, 9, 32'hDEAD, 1, 3, 32'h3, 32'h21C, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               1, 2, 32'h2, 32'h214, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               1, 4, 32'h4, 32'h210, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               1, 9, 32'hDEAD, 32'h200, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 9, 32'hDEAD, 32'h0, 1, 1);
        tbl[13] = mk(0, 1, 0, 32'hAA, 1, 0, 32'hBB, 0, 0, 0,     0, 9, 32'hDEAD, 32'h0, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 9, 32'hDEAD, 32'h0, 1, 1);
        tbl[15] = mk(0, 1, 7, 32'h55, 0, 0, 0, 0, 0, 0,          1, 7, 32'h55, 32'h80, 1, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 7, 32'h55, 32'h0, 1, 1);

        @(posedge clock); #1;
        for (int k = 0; k < 17; k++) begin
            resetn = !tbl[k].rst;
            alu_valid = tbl[k].av; alu_dest = tbl[k].ad; alu_data = tbl[k].adat;
            ld_valid = tbl[k].lv;  ld_dest = tbl[k].ld;  ld_data = tbl[k].ldat;
            md_valid = tbl[k].mv;  md_dest = tbl[k].md;  md_data = tbl[k].mdat;
            cycle();
            chk($sformatf("tbl%0d_wren", k), wren, tbl[k].e_wren);
            chk($sformatf("tbl%0d_pend", k), pending, tbl[k].e_pend);
            chk($sformatf("tbl%0d_ldr", k), ld_ready, tbl[k].e_ldr);
            chk($sformatf("tbl%0d_mdr", k), md_ready, tbl[k].e_mdr);
            if (tbl[k].e_wren || tbl[k].rst) begin
                chk($sformatf("tbl%0d_addr", k), wraddress, tbl[k].e_addr);
                chk($sformatf("tbl%0d_data", k), data, tbl[k].e_data);
            end
`ifdef WB_FWD_EN
            if (k == 15) begin
                rd_addr = 5'd7; rf_q = 32'h0; #1;
                chk("fwd_hit", rd_data, 32'h55);
                rd_addr = 5'd8; rf_q = 32'h99; #1;
                chk("fwd_miss", rd_data, 32'h99);
            end
`endif
        end

        // FIFO fills behind a solid ALU stream, then drains in order
        alu_valid = 0; ld_valid = 0; md_valid = 0;
        wlog.delete();
        li = 1; acc = 0;
        for (int c = 0; c < 40; c++) begin
            bit a;
            alu_valid = (c < 8); alu_dest = 5'd20; alu_data = 32'(c);
            ld_valid = (li <= 6); ld_dest = 5'(li); ld_data = 32'h100 + 32'(li);
            a = ld_valid && ld_ready;
            cycle();
            if (a) begin
                li++;
                if (c < 8) acc++;
            end
        end
        chk("full_accepted_under_alu", acc, 4);
        chk("full_all_loads_taken", li, 7);
        nld = 0;
        foreach (wlog[i]) if (wlog[i] != 20) begin
            nld++;
            chk($sformatf("drain_order%0d", nld), wlog[i], nld);
        end
        chk("drain_count", nld, 6);

        // Random traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            resetn    = ($urandom_range(0, 59) != 0);
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_dest  = 5'($urandom_range(0, 31)); alu_data = $urandom;
            ld_valid  = ($urandom_range(0, 1) == 0);
            ld_dest   = 5'($urandom_range(0, 31)); ld_data = $urandom;
            md_valid  = ($urandom_range(0, 3) == 0);
            md_dest   = 5'($urandom_range(0, 31)); md_data = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
